// File: rtl/hdlc_pkg.sv
// Shared constants and the bit-class enum for the HDLC receive deframer.
package hdlc_pkg;

    localparam logic [7:0]  FLAG_BYTE  = 8'h7E;
    localparam int unsigned ONES_STUFF = 5;
    localparam int unsigned ONES_FLAG  = 6;
    localparam int unsigned ONES_ABORT = 7;

    // A flag's leading 0 and six 1s reach the delay line as ordinary data
    // before the flag can be recognised; seven entries hold exactly those.
    localparam int unsigned DLY_LEN    = 7;

    typedef enum logic [2:0] {
        DATA,
        STUFF,
        FLAG,
        ABORT,
        IDLE
    } bit_class_t;

endpackage

// File: rtl/hdlc_rx_deframer_if.sv
// Serial line input and byte/frame event outputs of the HDLC deframer.
interface hdlc_rx_deframer_if;

    logic       in;
    logic       in_valid;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_first;
    logic       frame_end;
    logic       frame_err;
    logic       frame_abort;

    // Line source side
    modport master (
        output in, in_valid,
        input  byte_data, byte_valid, byte_first, frame_end, frame_err, frame_abort
    );

    // Deframer side
    modport slave (
        input  in, in_valid,
        output byte_data, byte_valid, byte_first, frame_end, frame_err, frame_abort
    );

endinterface

// File: rtl/hdlc_ones_classifier.sv
// Counts consecutive valid 1s and classifies the current valid bit from the
// count as it stood before this bit.
module hdlc_ones_classifier
    import hdlc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       in,
    input  logic       in_valid,
    output bit_class_t cls
);

    logic [2:0] ones;

    // Classify on the pre-update run length
    always_comb begin
        cls = DATA;
        if (!in && ones == 3'(ONES_STUFF))
            cls = STUFF;
        else if (!in && ones == 3'(ONES_FLAG))
            cls = FLAG;
        else if (in && ones == 3'(ONES_FLAG))
            cls = ABORT;
        else if (!in && ones == 3'(ONES_ABORT))
            cls = IDLE;
    end

    // Run-length counter of 1s, saturating, cleared by a 0
    always_ff @(posedge clk) begin
        if (reset)
            ones <= '0;
        else if (in_valid) begin
            if (!in)
                ones <= '0;
            else if (ones != 3'(ONES_ABORT))
                ones <= ones + 3'd1;
        end
    end

endmodule

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: destuffs the serial line, strips flags, assembles
// LSB-first bytes and reports frame end, misaligned close and abort.
module hdlc_rx_deframer
    import hdlc_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    hdlc_rx_deframer_if.slave  bus
);

    bit_class_t         cls;
    logic [DLY_LEN-1:0] dly_bit;
    logic [DLY_LEN-1:0] dly_tag;
    logic               pop_bit;
    logic               pop_vld;
    logic               in_frame;
    logic               byte_seen;
    logic [2:0]         bit_cnt;
    logic [7:0]         asm_q;

    hdlc_ones_classifier u_cls (
        .clk      (clk),
        .reset    (reset),
        .in       (bus.in),
        .in_valid (bus.in_valid),
        .cls      (cls)
    );

    // Oldest delay-line entry, shifted into the assembler on the next push
    assign pop_bit = dly_bit[DLY_LEN-1];
    assign pop_vld = dly_tag[DLY_LEN-1];

    // Delay line, byte assembly and frame control with registered event pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            dly_bit         <= '0;
            dly_tag         <= '0;
            in_frame        <= 1'b0;
            byte_seen       <= 1'b0;
            bit_cnt         <= '0;
            asm_q           <= '0;
            bus.byte_data   <= 8'h00;
            bus.byte_valid  <= 1'b0;
            bus.byte_first  <= 1'b0;
            bus.frame_end   <= 1'b0;
            bus.frame_err   <= 1'b0;
            bus.frame_abort <= 1'b0;
        end else begin
            bus.byte_valid  <= 1'b0;
            bus.byte_first  <= 1'b0;
            bus.frame_end   <= 1'b0;
            bus.frame_err   <= 1'b0;
            bus.frame_abort <= 1'b0;
            if (bus.in_valid) begin
                case (cls)
                    DATA: begin
                        dly_bit <= {dly_bit[DLY_LEN-2:0], bus.in};
                        dly_tag <= {dly_tag[DLY_LEN-2:0], 1'b1};
                        if (pop_vld && in_frame) begin
                            asm_q[bit_cnt] <= pop_bit;
                            bit_cnt        <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                bus.byte_data  <= {pop_bit, asm_q[6:0]};
                                bus.byte_valid <= 1'b1;
                                bus.byte_first <= !byte_seen;
                                byte_seen      <= 1'b1;
                            end
                        end
                    end
                    FLAG: begin
                        // Discard the flag's own bits still in the line
                        dly_tag <= '0;
                        if (in_frame) begin
                            if (bit_cnt != 3'd0)
                                bus.frame_err <= 1'b1;
                            else if (byte_seen)
                                bus.frame_end <= 1'b1;
                        end
                        // Every flag also opens the next frame
                        in_frame  <= 1'b1;
                        bit_cnt   <= '0;
                        byte_seen <= 1'b0;
                    end
                    ABORT: begin
                        dly_tag <= '0;
                        if (in_frame)
                            bus.frame_abort <= 1'b1;
                        in_frame <= 1'b0;
                    end
                    default: ;  // STUFF dropped, IDLE ignored
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Self-checking bench: a stuffing transmitter model builds the line and
// predicts byte/frame events from frame contents.
module tb_hdlc_rx_deframer;
    import hdlc_pkg::*;

    localparam logic [15:0] EV_END   = 16'h0200;
    localparam logic [15:0] EV_ERR   = 16'h0300;
    localparam logic [15:0] EV_ABORT = 16'h0400;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hdlc_rx_deframer_if bus();
    hdlc_rx_deframer dut (.clk(clk), .reset(reset), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;
    int multi   = 0;

    logic        line_q[$];
    logic        cur_bits[$];
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    bit          m_in_frame = 0;
    int          run = 0;

    // Monitor: record every event pulse seen after each active edge
    always @(negedge clk) begin
        int np;
        if (!reset) begin
            np = int'(bus.byte_valid) + int'(bus.frame_end) + int'(bus.frame_err) + int'(bus.frame_abort);
            if (np > 1) multi++;
            if (bus.byte_valid)  obs_q.push_back({4'h1, 3'b000, bus.byte_first, bus.byte_data});
            if (bus.frame_end)   obs_q.push_back(EV_END);
            if (bus.frame_err)   obs_q.push_back(EV_ERR);
            if (bus.frame_abort) obs_q.push_back(EV_ABORT);
        end
    end

    // ---------------- reference model ----------------
    task automatic deliver(int nbits);
        for (int k = 0; k < nbits / 8; k++) begin
            logic [7:0] b;
            for (int j = 0; j < 8; j++) b[j] = cur_bits[8*k + j];
            exp_q.push_back({4'h1, 3'b000, (k == 0), b});
        end
    endtask

    task automatic tx_flag();
        logic [7:0] f;
        f = FLAG_BYTE;
        if (m_in_frame) begin
            deliver(cur_bits.size());
            if (cur_bits.size() % 8 != 0) exp_q.push_back(EV_ERR);
            else if (cur_bits.size() > 0) exp_q.push_back(EV_END);
        end
        for (int j = 0; j < 8; j++) line_q.push_back(f[j]);
        m_in_frame = 1;
        cur_bits.delete();
        run = 0;
    endtask

    // Transmitter inserts a 0 after every five consecutive data 1s
    task automatic tx_bit(logic b);
        line_q.push_back(b);
        if (m_in_frame) cur_bits.push_back(b);
        if (b) run++; else run = 0;
        if (run == 5) begin
            line_q.push_back(1'b0);
            run = 0;
        end
    endtask

    task automatic tx_byte(logic [7:0] b);
        for (int j = 0; j < 8; j++) tx_bit(b[j]);
    endtask

    // Data is only recognised seven line bits late, so an abort (whose
    // first six 1s still count as data) loses the frame's final data bit.
    // Used only after data ending in 0.
    task automatic tx_abort();
        if (m_in_frame) begin
            deliver(cur_bits.size() > 0 ? cur_bits.size() - 1 : 0);
            exp_q.push_back(EV_ABORT);
        end
        for (int j = 0; j < 7; j++) line_q.push_back(1'b1);
        m_in_frame = 0;
        cur_bits.delete();
        run = 0;
    endtask

    task automatic run_line(int max_gap);
        foreach (line_q[i]) begin
            repeat ($urandom_range(max_gap, 0)) begin
                @(negedge clk);
                bus.in = 1'($urandom);
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            bus.in = line_q[i];
            bus.in_valid = 1'b1;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        line_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        bus.in = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (bus.byte_data !== 8'h00) begin n_fail++; $display("FAIL reset byte_data: got %h expected 00", bus.byte_data); end
        n_tests++; if (bus.byte_valid !== 1'b0) begin n_fail++; $display("FAIL reset byte_valid: got %b expected 0", bus.byte_valid); end
        n_tests++; if (bus.byte_first !== 1'b0) begin n_fail++; $display("FAIL reset byte_first: got %b expected 0", bus.byte_first); end
        n_tests++; if (bus.frame_end !== 1'b0) begin n_fail++; $display("FAIL reset frame_end: got %b expected 0", bus.frame_end); end
        n_tests++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset frame_err: got %b expected 0", bus.frame_err); end
        n_tests++; if (bus.frame_abort !== 1'b0) begin n_fail++; $display("FAIL reset frame_abort: got %b expected 0", bus.frame_abort); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_good_frame();
        tx_flag(); tx_byte(8'h3C); tx_flag();
        run_line(0);
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL good_frame count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL good_frame ev%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_stuffing();
        tx_flag(); tx_byte(8'hFF); tx_flag();
        run_line(0);
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stuffing count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stuffing ev%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    // Two 55 bytes so the first completes before the abort discards the tail
    task automatic test_abort();
        tx_flag(); tx_byte(8'h55); tx_byte(8'h55); tx_abort();
        tx_flag(); tx_byte(8'hA5); tx_flag();
        run_line(0);
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL abort count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL abort ev%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_misalign();
        tx_flag();
        for (int j = 0; j < 12; j++) tx_bit(1'($urandom));
        tx_flag();
        run_line(1);
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL misalign count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL misalign ev%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_idle_gaps();
        tx_flag(); tx_flag(); tx_flag();
        run_line(3);
        n_tests++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL idle_flags count: got %0d expected 0", obs_q.size()); end
        obs_q.delete(); exp_q.delete();
        tx_flag(); tx_byte(8'h3C); tx_flag();
        run_line(3);
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL gap_frame count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL gap_frame ev%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 6; f++) begin
            tx_flag();
            repeat ($urandom_range(4, 1)) tx_byte(8'($urandom));
        end
        tx_flag();
        run_line(2);
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL random_frames count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random_frames ev%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        // Leave byte_data non-zero, then reset on the 4th data bit of a frame
        tx_flag(); tx_byte(8'h3C); tx_flag();
        for (int j = 0; j < 3; j++) tx_bit(1'($urandom));
        run_line(0);
        @(negedge clk);
        bus.in = 1'($urandom);
        bus.in_valid = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        n_tests++; if (bus.byte_data !== 8'h00) begin n_fail++; $display("FAIL mid_reset byte_data: got %h expected 00", bus.byte_data); end
        n_tests++; if ({bus.byte_valid, bus.byte_first, bus.frame_end, bus.frame_err, bus.frame_abort} !== 5'b0)
            begin n_fail++; $display("FAIL mid_reset pulses: got %b expected 00000", {bus.byte_valid, bus.byte_first, bus.frame_end, bus.frame_err, bus.frame_abort}); end
        reset = 1'b0;
        bus.in_valid = 1'b0;
        m_in_frame = 0;
        cur_bits.delete();
        run = 0;
        // Stray data before the fresh flag must stay silent
        tx_byte(8'($urandom));
        tx_flag(); tx_byte(8'h3C); tx_flag();
        run_line(0);
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL mid_reset count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL mid_reset ev%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_one_pulse();
        n_tests++;
        if (multi != 0) begin n_fail++; $display("FAIL one_pulse: got %0d multi-pulse cycles expected 0", multi); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_stuffing();
        test_abort();
        test_misalign();
        test_idle_gaps();
        test_random_frames();
        test_reset_mid_frame();
        test_one_pulse();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
